// File: rtl/engine_ctrl_if.sv
// Control/handshake bundle between the engine sequencer and its sources/engine.
// Carries stat_frames/stat_stalls only when ENGINE_CTRL_STATS_EN is defined.
interface engine_ctrl_if #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int CNT_WIDTH    = 16
);
  logic                    start;
  logic [CNT_WIDTH-1:0]    cfg_frame_len;
  logic                    cfg_reuse;
  logic                    busy;
  logic [WEIGHT_WIDTH-1:0] wgt_data;
  logic                    wgt_valid;
  logic                    wgt_ready;
  logic [WEIGHT_WIDTH-1:0] eng_weight;
  logic                    eng_weight_valid;
  logic                    img_valid;
  logic                    img_ready;
  logic                    eng_image_valid;
  logic                    res_valid;
  logic                    res_last;
  logic                    frame_done;
`ifdef ENGINE_CTRL_STATS_EN
  logic [31:0]             stat_frames;
  logic [31:0]             stat_stalls;

  modport master (
    output start, cfg_frame_len, cfg_reuse, wgt_data, wgt_valid, img_valid,
    input  busy, wgt_ready, eng_weight, eng_weight_valid, img_ready, eng_image_valid,
           res_valid, res_last, frame_done, stat_frames, stat_stalls
  );
  modport slave (
    input  start, cfg_frame_len, cfg_reuse, wgt_data, wgt_valid, img_valid,
    output busy, wgt_ready, eng_weight, eng_weight_valid, img_ready, eng_image_valid,
           res_valid, res_last, frame_done, stat_frames, stat_stalls
  );
`else
  modport master (
    output start, cfg_frame_len, cfg_reuse, wgt_data, wgt_valid, img_valid,
    input  busy, wgt_ready, eng_weight, eng_weight_valid, img_ready, eng_image_valid,
           res_valid, res_last, frame_done
  );
  modport slave (
    input  start, cfg_frame_len, cfg_reuse, wgt_data, wgt_valid, img_valid,
    output busy, wgt_ready, eng_weight, eng_weight_valid, img_ready, eng_image_valid,
           res_valid, res_last, frame_done
  );
`endif
endinterface

// File: rtl/engine_ctrl.sv
// Convolution engine sequencer: kernel weight load, frame admission, result tracking.
// Optional frame/stall counters enabled by defining ENGINE_CTRL_STATS_EN.
module engine_ctrl #(
  parameter int WEIGHT_WIDTH  = 8,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int PIPE_LATENCY  = 4,
  parameter int CNT_WIDTH     = 16
) (
  input logic         clk,
  input logic         rst,
  engine_ctrl_if.slave bus
);
  localparam int KERNEL_NB = KERNEL_WIDTH * KERNEL_HEIGHT;
  localparam int WCNT_W    = $clog2(KERNEL_NB + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(KERNEL_NB - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StStream, StDrain, StDone} state_t;

  state_t                  r_state, w_state_next;
  logic [CNT_WIDTH-1:0]    r_len, r_icnt;
  logic [WCNT_W-1:0]       r_wcnt;
  logic                    r_loaded;
  logic [WEIGHT_WIDTH-1:0] r_eng_weight;
  logic                    r_eng_weight_valid;
  logic [PIPE_LATENCY-1:0] r_pipe_valid, r_pipe_last;

  logic w_wgt_ready, w_img_ready, w_frame_done;
  logic w_wgt_hs, w_img_hs, w_last_beat;

  assign w_wgt_hs    = bus.wgt_valid & w_wgt_ready;
  assign w_img_hs    = bus.img_valid & w_img_ready;
  // r_icnt never reaches r_len, so a full-scale length cannot wrap the compare
  assign w_last_beat = (r_icnt == (r_len - CNT_WIDTH'(1)));

  always_comb begin
    w_state_next = r_state;
    w_wgt_ready  = 1'b0;
    w_img_ready  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          if (bus.cfg_frame_len == '0)           w_state_next = StDone;
          else if (r_loaded && bus.cfg_reuse)    w_state_next = StStream;
          else                                   w_state_next = StLoad;
        end
      end
      StLoad: begin
        w_wgt_ready = 1'b1;
        if (bus.wgt_valid && (r_wcnt == WCNT_LAST)) w_state_next = StStream;
      end
      StStream: begin
        w_img_ready = 1'b1;
        if (bus.img_valid && w_last_beat) w_state_next = StDrain;
      end
      StDrain: begin
        if (r_pipe_last[PIPE_LATENCY-1]) w_state_next = StDone;
      end
      StDone: begin
        w_frame_done = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= StIdle;
      r_len              <= '0;
      r_icnt             <= '0;
      r_wcnt             <= '0;
      r_loaded           <= 1'b0;
      r_eng_weight       <= '0;
      r_eng_weight_valid <= 1'b0;
      r_pipe_valid       <= '0;
      r_pipe_last        <= '0;
    end else begin
      r_state            <= w_state_next;
      r_eng_weight_valid <= w_wgt_hs;
      if (w_wgt_hs) r_eng_weight <= bus.wgt_data;

      if (r_state == StIdle && bus.start) begin
        r_len  <= bus.cfg_frame_len;
        r_icnt <= '0;
        r_wcnt <= '0;
        if (w_state_next == StLoad) r_loaded <= 1'b0;
      end

      if (w_wgt_hs) begin
        if (r_wcnt == WCNT_LAST) begin
          r_wcnt   <= '0;
          r_loaded <= 1'b1;
        end else begin
          r_wcnt <= r_wcnt + WCNT_W'(1);
        end
      end

      if (w_img_hs) r_icnt <= r_icnt + CNT_WIDTH'(1);

      // Models the engine pipeline; shifts unconditionally
      r_pipe_valid[0] <= w_img_hs;
      r_pipe_last[0]  <= w_img_hs & w_last_beat;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_last[i]  <= r_pipe_last[i-1];
      end
    end
  end

  assign bus.busy             = (r_state != StIdle);
  assign bus.wgt_ready        = w_wgt_ready;
  assign bus.eng_weight       = r_eng_weight;
  assign bus.eng_weight_valid = r_eng_weight_valid;
  assign bus.img_ready        = w_img_ready;
  assign bus.eng_image_valid  = w_img_hs;
  assign bus.res_valid        = r_pipe_valid[PIPE_LATENCY-1];
  assign bus.res_last         = r_pipe_valid[PIPE_LATENCY-1] & r_pipe_last[PIPE_LATENCY-1];
  assign bus.frame_done       = w_frame_done;

`ifdef ENGINE_CTRL_STATS_EN
  logic [31:0] r_stat_frames, r_stat_stalls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_frames <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_frame_done && (r_stat_frames != '1)) r_stat_frames <= r_stat_frames + 32'd1;
      if ((r_state == StStream) && !bus.img_valid && (r_stat_stalls != '1)) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end
    end
  end

  assign bus.stat_frames = r_stat_frames;
  assign bus.stat_stalls = r_stat_stalls;
`endif
endmodule

// File: tb/tb_engine_ctrl.sv
// Directed bench for engine_ctrl: weight load, streaming, reuse, empty frame, mid-load reset.
// Stats counters are checked when ENGINE_CTRL_STATS_EN is defined.
module tb_engine_ctrl;
  localparam int WW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  engine_ctrl_if #(.WEIGHT_WIDTH(WW), .CNT_WIDTH(CW)) bus ();

  engine_ctrl #(
    .WEIGHT_WIDTH (WW),
    .KERNEL_WIDTH (3),
    .KERNEL_HEIGHT(3),
    .PIPE_LATENCY (4),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_wv    = 0;
  int n_rv    = 0;

  // Pulse counters sampled mid-cycle, well clear of both edges
  always begin
    @(posedge clk);
    #3;
    if (bus.eng_weight_valid === 1'b1) n_wv++;
    if (bus.res_valid === 1'b1) n_rv++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ten-cycle window of expected per-cycle outputs (bit k = k-th negedge)
  task automatic window(input string tag, input logic do_start, input logic [CW-1:0] len,
                        input logic reuse, input logic [9:0] e_busy, input logic [9:0] e_ir,
                        input logic [9:0] e_eiv, input logic [9:0] e_rv,
                        input logic [9:0] e_rl, input logic [9:0] e_fd);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("%s busy[%0d]", tag, k), bus.busy, e_busy[k]);
      check($sformatf("%s img_ready[%0d]", tag, k), bus.img_ready, e_ir[k]);
      check($sformatf("%s eng_image_valid[%0d]", tag, k), bus.eng_image_valid, e_eiv[k]);
      check($sformatf("%s res_valid[%0d]", tag, k), bus.res_valid, e_rv[k]);
      check($sformatf("%s res_last[%0d]", tag, k), bus.res_last, e_rl[k]);
      check($sformatf("%s frame_done[%0d]", tag, k), bus.frame_done, e_fd[k]);
      check($sformatf("%s wgt_ready[%0d]", tag, k), bus.wgt_ready, 0);
      if (k == 0 && do_start) begin
        bus.start         = 1'b1;
        bus.cfg_frame_len = len;
        bus.cfg_reuse     = reuse;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_img_ready(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.img_ready) seen = 1'b1;
      else @(negedge clk);
    end
    check(tag, seen, 1);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.frame_done) seen = 1'b1;
      else @(negedge clk);
    end
    check(tag, seen, 1);
  endtask

  initial begin
    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.cfg_frame_len = '0;
    bus.cfg_reuse     = 1'b0;
    bus.wgt_data      = '0;
    bus.wgt_valid     = 1'b0;
    bus.img_valid     = 1'b0;
    repeat (2) @(negedge clk);

    check("rst busy", bus.busy, 0);
    check("rst wgt_ready", bus.wgt_ready, 0);
    check("rst img_ready", bus.img_ready, 0);
    check("rst eng_weight", bus.eng_weight, 0);
    check("rst eng_weight_valid", bus.eng_weight_valid, 0);
    check("rst res_valid", bus.res_valid, 0);
    check("rst frame_done", bus.frame_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: load nine weights 1..9 with wgt_valid held high
    n_wv              = 0;
    bus.start         = 1'b1;
    bus.cfg_frame_len = CW'(4);
    bus.cfg_reuse     = 1'b0;
    bus.wgt_valid     = 1'b1;
    bus.img_valid     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("T1 busy", bus.busy, 1);
    check("T1 eng_image_valid gated in load", bus.eng_image_valid, 0);
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("T1 wgt_ready[%0d]", k), bus.wgt_ready, 1);
      if (k > 1) begin
        check($sformatf("T1 eng_weight_valid[%0d]", k - 1), bus.eng_weight_valid, 1);
        check($sformatf("T1 eng_weight[%0d]", k - 1), bus.eng_weight, k - 1);
      end
      bus.wgt_data = WW'(k);
      @(negedge clk);
    end
    check("T1 eng_weight_valid[9]", bus.eng_weight_valid, 1);
    check("T1 eng_weight[9]", bus.eng_weight, 9);
    check("T1 wgt_ready after 9", bus.wgt_ready, 0);
    check("T1 weight pulses", n_wv, 9);
    bus.wgt_data = WW'(10);

    // T2: four back-to-back beats, PIPE_LATENCY 4
    window("T2", 1'b0, CW'(0), 1'b0,
           10'b0111111111, 10'b0000001111, 10'b0000001111,
           10'b0011110000, 10'b0010000000, 10'b0100000000);
    check("T2 eng_weight held", bus.eng_weight, 9);
    check("T2 weight pulses", n_wv, 9);

    // T3: reuse loaded weights, len 3
    n_wv = 0;
    window("T3", 1'b1, CW'(3), 1'b1,
           10'b0111111110, 10'b0000001110, 10'b0000001110,
           10'b0011100000, 10'b0010000000, 10'b0100000000);
    check("T3 no weights taken", n_wv, 0);

    // T4: empty frame goes straight to done
    n_rv = 0;
    window("T4", 1'b1, CW'(0), 1'b0,
           10'b0000000010, 10'b0000000000, 10'b0000000000,
           10'b0000000000, 10'b0000000000, 10'b0000000010);
    check("T4 no weights taken", n_wv, 0);
    check("T4 no results", n_rv, 0);

    // T5: reset after five weights, then reuse request must still reload
    n_wv              = 0;
    bus.start         = 1'b1;
    bus.cfg_frame_len = CW'(2);
    bus.cfg_reuse     = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("T5 weights before rst", n_wv, 5);
    check("T5 rst busy", bus.busy, 0);
    check("T5 rst eng_weight", bus.eng_weight, 0);
    check("T5 rst eng_weight_valid", bus.eng_weight_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_wv              = 0;
    n_rv              = 0;
    bus.start         = 1'b1;
    bus.cfg_frame_len = CW'(2);
    bus.cfg_reuse     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("T5 load re-entered", bus.wgt_ready, 1);
    wait_img_ready("T5 reach stream");
    check("T5 weights reloaded", n_wv, 9);
    wait_done("T5 frame_done");
    check("T5 results", n_rv, 2);

    // T6: len 5 with three idle cycles inside the stream
    rst = 1'b1;
    @(negedge clk);
    rst               = 1'b0;
    bus.img_valid     = 1'b0;
    n_rv              = 0;
    bus.start         = 1'b1;
    bus.cfg_frame_len = CW'(5);
    bus.cfg_reuse     = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_img_ready("T6 reach stream");
    begin
      logic [7:0] pat;
      pat = 8'b1101_0101;
      for (int p = 0; p < 8; p++) begin
        bus.img_valid = pat[p];
        @(negedge clk);
      end
    end
    bus.img_valid = 1'b1;
    wait_done("T6 frame_done");
    @(negedge clk);
    check("T6 results", n_rv, 5);
    check("T6 idle after done", bus.busy, 0);
`ifdef ENGINE_CTRL_STATS_EN
    check("T6 stat_stalls", bus.stat_stalls, 3);
    check("T6 stat_frames", bus.stat_frames, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
